// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the traffic-light controller and its
// sensor front end: lane indices, lane count and the light FSM state encoding.
package traffic_pkg;

  // Lane indices; bit positions in every per-lane vector follow this order.
  localparam int NUM_LANES = 4;
  localparam int LANE_NS1  = 0;
  localparam int LANE_NS2  = 1;
  localparam int LANE_EW1  = 2;
  localparam int LANE_EW2  = 3;

  // Adaptive traffic-light FSM states. The S1_*/S5_* signals produced by the
  // sensor conditioner drive the transitions between these states.
  typedef enum logic [2:0] {
    ST_ALL_RED    = 3'd0,
    ST_NS_GREEN   = 3'd1,
    ST_NS_EXTEND  = 3'd2,
    ST_NS_YELLOW  = 3'd3,
    ST_EW_GREEN   = 3'd4,
    ST_EW_EXTEND  = 3'd5,
    ST_EW_YELLOW  = 3'd6
  } light_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser followed by a sample-strobed debounce
// counter. The debounced level flips on the DEBOUNCE_CYCLES-th consecutive
// sample that disagrees with it; any agreeing sample restarts the count, so
// the counter never exceeds DEBOUNCE_CYCLES-1.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic raw_i,
  output logic synced_o,
  output logic debounced_o
);

  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1_q;
  logic sync2_q;
  logic db_q;
  logic db_d;
  logic [CNT_W-1:0] dc_q;
  logic [CNT_W-1:0] dc_d;

  // Synchroniser runs every cycle, independent of the sampling strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: count disagreeing samples, flip level on the last one.
  always_comb begin
    db_d = db_q;
    dc_d = dc_q;
    if (sample_en_i) begin
      if (sync2_q != db_q) begin
        if (dc_q == DC_LAST) begin
          db_d = ~db_q;
          dc_d = '0;
        end else begin
          dc_d = dc_q + CNT_W'(1);
        end
      end else begin
        dc_d = '0;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= 1'b0;
      dc_q <= '0;
    end else begin
      db_q <= db_d;
      dc_q <= dc_d;
    end
  end

  assign synced_o    = sync2_q;
  assign debounced_o = db_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: per-lane demand (S1_*) and congestion (S5_*)
// conditioning for the traffic-light FSM. Each raw detector is synchronised
// and debounced; congestion additionally requires the debounced tail loop to
// stay occupied for CONG_THRESH samples.
// Optional stuck-detector supervision is built when TRAFFIC_SENSOR_FAULT_DET_EN
// is defined; otherwise fault is tied low.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CONG_THRESH     = 8,
  parameter int STUCK_CYCLES    = 255,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [3:0] raw_det,
  input  logic [3:0] raw_tail,
  output logic       S1_NS1,
  output logic       S1_NS2,
  output logic       S1_EW1,
  output logic       S1_EW2,
  output logic       S5_NS1,
  output logic       S5_NS2,
  output logic       S5_EW1,
  output logic       S5_EW2,
  output logic [3:0] fault
);

  localparam logic [CNT_W-1:0] OC_MAX = CNT_W'(CONG_THRESH);

  logic [NUM_LANES-1:0] det_sync;
  logic [NUM_LANES-1:0] det_db;
  logic [NUM_LANES-1:0] tail_sync;
  logic [NUM_LANES-1:0] tail_db;
  logic [NUM_LANES-1:0] s1_vec;
  logic [NUM_LANES-1:0] s5_vec;
  logic [NUM_LANES-1:0] fault_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [CNT_W-1:0] oc_q;
      logic [CNT_W-1:0] oc_d;
      logic             fault_q;
      logic             fault_d;
      logic             s1_q;
      logic             s1_d;
      logic             s5_q;
      logic             s5_d;

      sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_det (
        .clk         (clk),
        .rst         (rst),
        .sample_en_i (sample_en),
        .raw_i       (raw_det[gi]),
        .synced_o    (det_sync[gi]),
        .debounced_o (det_db[gi])
      );

      sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_tail (
        .clk         (clk),
        .rst         (rst),
        .sample_en_i (sample_en),
        .raw_i       (raw_tail[gi]),
        .synced_o    (tail_sync[gi]),
        .debounced_o (tail_db[gi])
      );

      // Occupancy: count debounced tail-high samples, saturate, clear on low.
      always_comb begin
        oc_d = oc_q;
        if (sample_en) begin
          if (!tail_db[gi]) begin
            oc_d = '0;
          end else if (oc_q != OC_MAX) begin
            oc_d = oc_q + CNT_W'(1);
          end
        end
      end

      // Occupancy counter register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          oc_q <= '0;
        end else begin
          oc_q <= oc_d;
        end
      end

`ifdef TRAFFIC_SENSOR_FAULT_DET_EN
      localparam logic [CNT_W-1:0] STK_MAX = CNT_W'(STUCK_CYCLES);
      logic [CNT_W-1:0] stk_q;
      logic [CNT_W-1:0] stk_d;

      // Stuck supervision: a demand detector high for STUCK_CYCLES samples is
      // flagged; the flag holds until the debounced demand finally drops.
      always_comb begin
        stk_d   = stk_q;
        fault_d = fault_q;
        if (sample_en) begin
          if (!det_sync[gi]) begin
            stk_d = '0;
          end else if (stk_q != STK_MAX) begin
            stk_d = stk_q + CNT_W'(1);
          end
          if (!det_db[gi]) begin
            fault_d = 1'b0;
          end else if (stk_q == STK_MAX) begin
            fault_d = 1'b1;
          end
        end
      end

      // Stuck counter and fault flag registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stk_q   <= '0;
          fault_q <= 1'b0;
        end else begin
          stk_q   <= stk_d;
          fault_q <= fault_d;
        end
      end
`else
      assign fault_d = 1'b0;
      assign fault_q = 1'b0;
`endif

      // Output next state; a faulted lane requests green but never extends it.
      // Congestion drops as soon as the debounced tail is low.
      always_comb begin
        s1_d = s1_q;
        s5_d = s5_q;
        if (sample_en) begin
          s1_d = det_db[gi] | fault_d;
          s5_d = !fault_d && tail_db[gi] && (oc_q == OC_MAX);
        end
      end

      // Output registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q <= 1'b0;
          s5_q <= 1'b0;
        end else begin
          s1_q <= s1_d;
          s5_q <= s5_d;
        end
      end

      assign s1_vec[gi]    = s1_q;
      assign s5_vec[gi]    = s5_q;
      assign fault_vec[gi] = fault_q;
    end
  endgenerate

  // Synced levels not consumed in this build configuration.
`ifdef TRAFFIC_SENSOR_FAULT_DET_EN
  logic unused_sync;
  assign unused_sync = ^tail_sync;
`else
  logic unused_sync;
  assign unused_sync = ^{det_sync, tail_sync, CNT_W'(STUCK_CYCLES)};
`endif

  assign S1_NS1 = s1_vec[LANE_NS1];
  assign S1_NS2 = s1_vec[LANE_NS2];
  assign S1_EW1 = s1_vec[LANE_EW1];
  assign S1_EW2 = s1_vec[LANE_EW2];
  assign S5_NS1 = s5_vec[LANE_NS1];
  assign S5_NS2 = s5_vec[LANE_NS2];
  assign S5_EW1 = s5_vec[LANE_EW1];
  assign S5_EW2 = s5_vec[LANE_EW2];
  assign fault  = fault_vec;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: directed stimulus with hand-computed
// expectations, plus a per-cycle comparison against a streak-count model.
module tb_traffic_sensor_conditioner;

  localparam int D = 4;
  localparam int C = 8;
  localparam int S = 255;
`ifdef TRAFFIC_SENSOR_FAULT_DET_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] raw_det   = 4'h0;
  logic [3:0] raw_tail  = 4'h0;
  logic       S1_NS1, S1_NS2, S1_EW1, S1_EW2;
  logic       S5_NS1, S5_NS2, S5_EW1, S5_EW2;
  logic [3:0] fault;
  logic [11:0] outs;

  int checks = 0;
  int passes = 0;

  traffic_sensor_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .raw_det   (raw_det),
    .raw_tail  (raw_tail),
    .S1_NS1    (S1_NS1),
    .S1_NS2    (S1_NS2),
    .S1_EW1    (S1_EW1),
    .S1_EW2    (S1_EW2),
    .S5_NS1    (S5_NS1),
    .S5_NS2    (S5_NS2),
    .S5_EW1    (S5_EW1),
    .S5_EW2    (S5_EW2),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // outs[3:0] = S1, outs[7:4] = S5, outs[11:8] = fault (lane order NS1..EW2)
  assign outs = {fault, S5_EW2, S5_EW1, S5_NS2, S5_NS1, S1_EW2, S1_EW1, S1_NS2, S1_NS1};

  // ---------------- behavioural model ----------------
  // Index 0..3 demand detectors, 4..7 tail loops.
  logic [7:0] m_sy1 = '0, m_sy2 = '0, m_db = '0, m_db_pre;
  int         m_dis [8];
  int         m_tail_run [4];
  int         m_hi_run [4];
  int         m_prev_hi;
  logic [3:0] m_s1 = '0, m_s5 = '0, m_fault = '0;

  initial begin : model
    for (int j = 0; j < 8; j++) m_dis[j] = 0;
    for (int l = 0; l < 4; l++) begin m_tail_run[l] = 0; m_hi_run[l] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_sy1 = '0; m_sy2 = '0; m_db = '0;
        m_s1 = '0; m_s5 = '0; m_fault = '0;
        for (int j = 0; j < 8; j++) m_dis[j] = 0;
        for (int l = 0; l < 4; l++) begin m_tail_run[l] = 0; m_hi_run[l] = 0; end
      end else begin
        if (sample_en) begin
          m_db_pre = m_db;
          // Level flips after D consecutive disagreeing samples.
          for (int j = 0; j < 8; j++) begin
            if (m_sy2[j] != m_db[j]) begin
              m_dis[j] = m_dis[j] + 1;
              if (m_dis[j] == D) begin
                m_db[j]  = ~m_db[j];
                m_dis[j] = 0;
              end
            end else begin
              m_dis[j] = 0;
            end
          end
          for (int l = 0; l < 4; l++) begin
            // Streak of samples with debounced tail high; congested once
            // the streak exceeds the threshold.
            m_tail_run[l] = m_db_pre[4+l] ? ((m_tail_run[l] < 1000) ? m_tail_run[l] + 1 : 1000) : 0;
            m_prev_hi     = m_hi_run[l];
            m_hi_run[l]   = m_sy2[l] ? ((m_hi_run[l] < 1000) ? m_hi_run[l] + 1 : 1000) : 0;
            if (FAULT_EN)
              m_fault[l] = m_db_pre[l] && (m_fault[l] || (m_prev_hi >= S));
            m_s1[l] = m_db_pre[l] | m_fault[l];
            m_s5[l] = !m_fault[l] && (m_tail_run[l] >= C + 1);
          end
        end
        m_sy2 = m_sy1;
        m_sy1 = {raw_tail, raw_det};
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (outs === {m_fault, m_s5, m_s1}) passes++;
    else $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, outs, {m_fault, m_s5, m_s1});
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string name, input logic [11:0] mask, input logic [11:0] exp);
    checks++;
    if ((outs & mask) === exp) begin
      passes++;
      $display("ok   %s got=%h expected=%h", name, outs & mask, exp);
    end else begin
      $display("FAIL %s got=%h expected=%h", name, outs & mask, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
      $display("ok   %s got=%0d expected=%0d", name, act, exp);
    end else begin
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int hits;
    step(3);
    check_out("reset_outputs", 12'hFFF, 12'h000);
    rst = 1'b0;
    sample_en = 1'b1;
    step(2);

    // Demand pulse: S1_NS1 rises on the 7th edge after the raw change.
    raw_det[0] = 1'b1;
    step(6);
    check_out("demand_edge6", 12'h0FF, 12'h000);
    step(1);
    check_out("demand_edge7", 12'hFFF, 12'h001);
    raw_det[0] = 1'b0;
    step(7);
    check_out("demand_release", 12'h00F, 12'h000);

    // Glitch: two 3-sample glitches separated by quiet time never flip.
    hits = 0;
    for (int g = 0; g < 2; g++) begin
      raw_det[2] = 1'b1;
      step(3);
      raw_det[2] = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step(1);
        if (S1_EW1) hits++;
      end
    end
    check_int("glitch_ew1_high_cycles", hits, 0);

    // Congestion on NS2: asserts on edge 15, drops one edge after db falls.
    raw_tail[1] = 1'b1;
    step(14);
    check_out("cong_edge14", 12'h0F0, 12'h000);
    step(1);
    check_out("cong_edge15", 12'hFFF, 12'h020);
    step(5);
    raw_tail[1] = 1'b0;
    step(6);
    check_out("cong_db_fall_edge", 12'h0F0, 12'h020);
    step(1);
    check_out("cong_drop", 12'hFFF, 12'h000);
    step(4);

    // Strobe gating: one sample every 4 cycles; S1_NS2 on the 5th strobe.
    raw_det[1] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      sample_en = 1'b0;
      step(3);
      sample_en = 1'b1;
      step(1);
    end
    check_out("strobe_after_4", 12'h00F, 12'h000);
    sample_en = 1'b0;
    step(3);
    check_out("strobe_hold_low", 12'h00F, 12'h000);
    sample_en = 1'b1;
    step(1);
    check_out("strobe_after_5", 12'hFFF, 12'h002);
    sample_en = 1'b0;
    raw_det[1] = 1'b0;
    step(8);
    check_out("strobe_hold_high", 12'h00F, 12'h002);
    sample_en = 1'b1;
    step(8);
    check_out("strobe_release", 12'hFFF, 12'h000);

    // Reset mid-count (oc = 5 on EW2) clears outputs immediately.
    raw_det[0]  = 1'b1;
    raw_tail[3] = 1'b1;
    step(11);
    check_out("pre_reset", 12'hFFF, 12'h001);
    #2 rst = 1'b1;
    #1 check_out("async_reset", 12'hFFF, 12'h000);
    step(2);
    rst = 1'b0;
    step(14);
    check_out("post_reset_edge14", 12'h0F0, 12'h000);
    step(1);
    check_out("post_reset_edge15", 12'hFFF, 12'h081);

    // All eight inputs rise together.
    raw_det  = 4'h0;
    raw_tail = 4'h0;
    step(12);
    check_out("all_clear", 12'hFFF, 12'h000);
    raw_det  = 4'hF;
    raw_tail = 4'hF;
    step(7);
    check_out("all_demand", 12'hFFF, 12'h00F);
    step(8);
    check_out("all_congest", 12'hFFF, 12'h0FF);

    // Stuck demand detector on EW2 with its tail loop occupied.
    raw_det  = 4'h0;
    raw_tail = 4'h0;
    step(12);
    raw_det[3]  = 1'b1;
    raw_tail[3] = 1'b1;
    step(300);
    check_out("stuck_300", 12'hFFF, FAULT_EN ? 12'h808 : 12'h088);
    raw_det[3] = 1'b0;
    step(6);
    check_out("stuck_db_fall_edge", 12'hF00, FAULT_EN ? 12'h800 : 12'h000);
    step(1);
    check_out("stuck_cleared", 12'hFFF, 12'h080);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Upstream conditioning stage for the adaptive traffic-light FSM. It takes raw, noisy vehicle-detector inputs for the four lanes (NS1, NS2, EW1, EW2) and produces clean, registered per-lane signals:
- demand (`S1_*`), the start-of-lane presence sensor;
- congestion (`S5_*`), the queue-tail loop occupied long enough to justify a green extension.

These outputs connect one-to-one to the FSM's `S1_*`/`S5_*` inputs. Each raw input is synchronised, debounced and, for congestion, dwell-qualified.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive disagreeing samples needed to flip a debounced level (≥1).
- `CONG_THRESH`, default 8: consecutive occupied samples on the tail loop before congestion asserts (≥1).
- `STUCK_CYCLES`, default 255: consecutive high samples on a demand detector before it is declared stuck (fault feature only).
- `CNT_W`, default 8: width of all internal counters. Must hold max(DEBOUNCE_CYCLES, CONG_THRESH, STUCK_CYCLES).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `sample_en`  in  1  sampling strobe; counters advance only when high
- `raw_det`  in  4  raw demand detectors; bit0 NS1, bit1 NS2, bit2 EW1, bit3 EW2; asynchronous
- `raw_tail`  in  4  raw queue-tail loop detectors, same bit order; asynchronous
- `S1_NS1`, `S1_NS2`, `S1_EW1`, `S1_EW2`  out  1 each  conditioned demand
- `S5_NS1`, `S5_NS2`, `S5_EW1`, `S5_EW2`  out  1 each  conditioned congestion
- `fault`  out  4  per-lane stuck-detector flag, same bit order

## Operation
- **Synchroniser.** Every `raw_det` and `raw_tail` bit passes through a 2-flop synchroniser clocked every cycle, independent of `sample_en`.
- **Debounce (per signal).**
  - The debounced level `db` and counter `dc` update only on `sample_en`.
  - If the synced value ≠ `db`: `dc` increments. When `dc` reaches `DEBOUNCE_CYCLES`, `db` flips and `dc` clears.
  - If the synced value = `db`: `dc` clears. Any agreeing sample restarts the count.
- **Demand.** `S1_x` is the debounced `raw_det` for lane x, registered.
- **Congestion.**
  - Occupancy counter `oc` per lane, updated on `sample_en`.
  - Debounced tail high: `oc` increments, saturating at `CONG_THRESH`.
  - Debounced tail low: `oc` clears immediately.
  - `S5_x` = (`oc` == `CONG_THRESH`), registered.
  - `S5_x` deasserts on the cycle after the debounced tail falls.
- **Independence.** Lanes are fully independent. Simultaneous events on all eight inputs are each processed in the same cycle, with no priority.
- **No sample_en.** With `sample_en` held low, all counters and outputs hold. Synchronisers keep running.

## Timing
- **Reset values.** All outputs reset to 0. All `db`, `dc`, `oc`, stuck counters and synchroniser flops reset to 0.
- **Reset mid-operation.** Reset asynchronously clears everything regardless of counts in progress. First sampling occurs on the first `sample_en` after `rst` deasserts.
- **Demand latency** (with `sample_en` constantly high): the `S1_x` register updates on clock edge 2+`DEBOUNCE_CYCLES`+1, counted from the edge that first captures a stable raw change.
- **Congestion latency:** `S5_x` asserts `CONG_THRESH`+1 edges after the debounced tail rises.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` samples never reaches the outputs.
- **Counter limits:** counters never wrap. The occupancy and stuck counters saturate at their thresholds.

## Configuration
- Macro `TRAFFIC_SENSOR_FAULT_DET_EN`.
- **Defined:**
  - Per lane, a stuck counter increments on `sample_en` while the synced `raw_det` is high, saturating at `STUCK_CYCLES`. It clears when the synced `raw_det` is low.
  - When it reaches `STUCK_CYCLES`, `fault[x]` sets.
  - While `fault[x]` is set: `S1_x` is forced to 1 (fail-safe demand) and `S5_x` is forced to 0 (no green extension).
  - `fault[x]` clears when the debounced `raw_det` falls.
- **Undefined:** no stuck logic is generated, `fault` is tied to 4'b0000, and outputs follow normal operation.

## Structure
- **Shared package `traffic_pkg`:** lane index constants `LANE_NS1`=0, `LANE_NS2`=1, `LANE_EW1`=2, `LANE_EW2`=3, plus `NUM_LANES`=4. The FSM state encodings also move there for shared use.
- **Sub-module `sensor_debounce`:** 2-flop synchroniser plus debounce counter, with parameter `DEBOUNCE_CYCLES` and outputs synced and debounced level. Instantiated 8 times (4 demand, 4 tail).
- **Top level:** occupancy counters, stuck logic and output registers live in the top.

## Test plan
- **Demand pulse:** `raw_det`[0] held high from cycle 10, `sample_en`=1 → `S1_NS1` rises exactly 7 edges later. The other S1/S5 outputs stay 0.
- **Glitch:** `raw_det`[2] high for 3 samples then low → `S1_EW1` never asserts. `dc` returns to 0.
- **Congestion:** `raw_tail`[1] held high for 20 samples → `S5_NS2` asserts at sample 4+8+1. It drops one cycle after the debounced tail falls.
- **Strobe gating:** `sample_en` toggling every 4th cycle → latencies scale by 4. Outputs hold between strobes.
- **Reset mid-count:** `rst` pulsed while `oc`=5 → all outputs are 0 immediately. Congestion needs the full `CONG_THRESH` again.
- **Stuck detector (macro defined):** `raw_det`[3] high for 300 samples with `raw_tail`[3] high → `fault`[3]=1, `S1_EW2`=1, `S5_EW2`=0. When `raw_det`[3] goes low, `fault`[3] clears after debounce.
